// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game engine.
//   - cell codes stored per board square (2 bits each)
//   - game FSM state encoding
//   - 3-bit {R,G,B} colour constants used by the renderer
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        P1_TURN,
        P2_TURN,
        CHECK,
        WIN,
        DRAW
    } state_t;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] CYAN   = 3'b011;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] GREEN  = 3'b010;

endpackage

// File: rtl/ttt_pixel_map.sv
// Maps a screen pixel onto the N x N board.
//   pixel_x / pixel_y : current pixel position
//   cell_row/cell_col : board cell that contains the pixel (clamped to N-1)
//   on_grid_line      : pixel lies on one of the inner grid lines
// Purely combinational; uses constant comparisons only, no divider.
module ttt_pixel_map #(
    parameter int N          = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int LINE_WIDTH = 3,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE),
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [XW-1:0] pixel_x,
    input  logic [YW-1:0] pixel_y,
    output logic [RW-1:0] cell_row,
    output logic [RW-1:0] cell_col,
    output logic          on_grid_line
);

    localparam int CW = H_ACTIVE / N;
    localparam int CH = V_ACTIVE / N;

    // Boundaries are tested in increasing order, so the last hit wins and the
    // result is the largest boundary not exceeding the pixel; pixels past the
    // final boundary (integer-division remainder) stay in cell N-1.
    always_comb begin
        cell_row     = '0;
        cell_col     = '0;
        on_grid_line = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (int'(pixel_x) >= k * CW) cell_col = RW'(k);
            if (int'(pixel_y) >= k * CH) cell_row = RW'(k);
            if (int'(pixel_x) >= k * CW - 1 && int'(pixel_x) <= k * CW - 2 + LINE_WIDTH)
                on_grid_line = 1'b1;
            if (int'(pixel_y) >= k * CH - 1 && int'(pixel_y) <= k * CH - 2 + LINE_WIDTH)
                on_grid_line = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_game_engine.sv
// Tic-tac-toe game engine: board storage, cursor, turn FSM, sequential
// win/draw scan and VGA pixel colouring.
//   clk, clr (async active-low reset)
//   vga_on, pixel_x, pixel_y      : from the VGA timing block
//   btn_up/down/left/right        : cursor move pulses
//   btn_select                    : place mark at cursor
//   btn_start                     : clear board, new game (any state)
//   vga_red/green/blue            : registered pixel colour
//   player_1_win/player_2_win/draw: result flags
//   turn                          : 0 = player 1 to move, 1 = player 2
//   game_active                   : high in P1_TURN, P2_TURN, CHECK
module ttt_game_engine
    import ttt_pkg::*;
#(
    parameter int N          = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int LINE_WIDTH = 3,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vga_on,
    input  logic [X_BITS-1:0] pixel_x,
    input  logic [Y_BITS-1:0] pixel_y,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_select,
    input  logic              btn_start,
    output logic              vga_red,
    output logic              vga_green,
    output logic              vga_blue,
    output logic              player_1_win,
    output logic              player_2_win,
    output logic              draw,
    output logic              turn,
    output logic              game_active
);

    localparam int RW        = (N > 1) ? $clog2(N) : 1;
    localparam int IW        = (N > 1) ? $clog2(N * N) : 1;
    localparam int CNT_W     = $clog2(N * N + 1);
    localparam int SW        = $clog2(2 * N + 2);
    localparam int LAST_LINE = 2 * N + 1;
    localparam int CENTRE    = N / 2;

    typedef logic [N*N-1:0][1:0] board_t;

    state_t           state, state_nxt;
    board_t           board, board_nxt;
    logic [RW-1:0]    cur_row, cur_row_nxt, cur_col, cur_col_nxt;
    logic [CNT_W-1:0] moves, moves_nxt;
    logic [SW-1:0]    scan, scan_nxt;
    logic             mover, mover_nxt;
    logic             p1_win_nxt, p2_win_nxt, draw_nxt;
    logic [IW-1:0]    cur_idx;
    logic [1:0]       mover_code;

    // Line index: 0..N-1 rows, N..2N-1 columns, 2N main diagonal,
    // 2N+1 anti-diagonal. True when every cell on it holds `code`.
    function automatic logic line_full(board_t b, logic [SW-1:0] idx, logic [1:0] code);
        int   li, r, c;
        logic full;
        li   = int'(idx);
        full = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (li < N) begin
                r = li; c = k;
            end else if (li < 2 * N) begin
                r = k;  c = li - N;
            end else if (li == 2 * N) begin
                r = k;  c = k;
            end else begin
                r = k;  c = N - 1 - k;
            end
            if (b[IW'(r * N + c)] != code) full = 1'b0;
        end
        return full;
    endfunction

    assign cur_idx     = IW'(int'(cur_row) * N + int'(cur_col));
    assign mover_code  = mover ? P2 : P1;
    assign turn        = mover;
    assign game_active = (state == P1_TURN) || (state == P2_TURN) || (state == CHECK);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            board        <= '0;
            cur_row      <= RW'(CENTRE);
            cur_col      <= RW'(CENTRE);
            moves        <= '0;
            scan         <= '0;
            mover        <= 1'b0;
            player_1_win <= 1'b0;
            player_2_win <= 1'b0;
            draw         <= 1'b0;
        end else begin
            state        <= state_nxt;
            board        <= board_nxt;
            cur_row      <= cur_row_nxt;
            cur_col      <= cur_col_nxt;
            moves        <= moves_nxt;
            scan         <= scan_nxt;
            mover        <= mover_nxt;
            player_1_win <= p1_win_nxt;
            player_2_win <= p2_win_nxt;
            draw         <= draw_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        board_nxt   = board;
        cur_row_nxt = cur_row;
        cur_col_nxt = cur_col;
        moves_nxt   = moves;
        scan_nxt    = scan;
        mover_nxt   = mover;
        p1_win_nxt  = player_1_win;
        p2_win_nxt  = player_2_win;
        draw_nxt    = draw;
        if (btn_start) begin
            state_nxt   = P1_TURN;
            board_nxt   = '0;
            cur_row_nxt = RW'(CENTRE);
            cur_col_nxt = RW'(CENTRE);
            moves_nxt   = '0;
            scan_nxt    = '0;
            mover_nxt   = 1'b0;
            p1_win_nxt  = 1'b0;
            p2_win_nxt  = 1'b0;
            draw_nxt    = 1'b0;
        end else begin
            case (state)
                P1_TURN, P2_TURN: begin
                    if (btn_select) begin
                        // Occupied cell: the press is simply dropped.
                        if (board[cur_idx] == EMPTY) begin
                            board_nxt[cur_idx] = (state == P2_TURN) ? P2 : P1;
                            moves_nxt          = moves + 1'b1;
                            mover_nxt          = (state == P2_TURN);
                            scan_nxt           = '0;
                            state_nxt          = CHECK;
                        end
                    end else if (btn_up) begin
                        cur_row_nxt = (cur_row == '0) ? RW'(N - 1) : cur_row - 1'b1;
                    end else if (btn_down) begin
                        cur_row_nxt = (int'(cur_row) == N - 1) ? '0 : cur_row + 1'b1;
                    end else if (btn_left) begin
                        cur_col_nxt = (cur_col == '0) ? RW'(N - 1) : cur_col - 1'b1;
                    end else if (btn_right) begin
                        cur_col_nxt = (int'(cur_col) == N - 1) ? '0 : cur_col + 1'b1;
                    end
                end
                CHECK: begin
                    // Only the last mover can have completed a line.
                    if (line_full(board, scan, mover_code)) begin
                        state_nxt = WIN;
                        if (mover) p2_win_nxt = 1'b1;
                        else       p1_win_nxt = 1'b1;
                    end else if (int'(scan) == LAST_LINE) begin
                        if (int'(moves) == N * N) begin
                            state_nxt = DRAW;
                            draw_nxt  = 1'b1;
                        end else begin
                            state_nxt = mover ? P1_TURN : P2_TURN;
                            mover_nxt = ~mover;
                        end
                    end else begin
                        scan_nxt = scan + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- pixel rendering ----------------
    logic [RW-1:0] cell_row, cell_col;
    logic          on_grid;
    logic [IW-1:0] pix_idx;
    logic [1:0]    pix_cell;
    logic [2:0]    colour, colour_nxt;

    ttt_pixel_map #(
        .N          (N),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_pixel_map (
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .on_grid_line (on_grid)
    );

    assign pix_idx  = IW'(int'(cell_row) * N + int'(cell_col));
    assign pix_cell = board[pix_idx];

    always_comb begin
        colour_nxt = CYAN;
        if (!vga_on || on_grid)                        colour_nxt = BLACK;
        else if (pix_cell == P1)                       colour_nxt = RED;
        else if (pix_cell == P2)                       colour_nxt = BLUE;
        else if (pix_idx == cur_idx && game_active)    colour_nxt = (pix_cell == EMPTY) ? YELLOW : WHITE;
        else if (state == WIN)                         colour_nxt = GREEN;
        else if (state == DRAW)                        colour_nxt = WHITE;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) colour <= BLACK;
        else      colour <= colour_nxt;
    end

    assign {vga_red, vga_green, vga_blue} = colour;

endmodule
